// File: rtl/fifo_pkg.sv
// Shared constants and payload types for the byte FIFO and its word packer.
package fifo_pkg;

   localparam int unsigned FIFO_WIDTH     = 3;
   localparam int unsigned FIFO_SIZE      = 1 << FIFO_WIDTH;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD) + 1;
   localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic [CNT_W-1:0]  bytes;
   } word_t;

endpackage

// File: rtl/word_out_slot.sv
// One-entry valid/ready holding register presenting packed words downstream.
module word_out_slot
   import fifo_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  word_t             load_word,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_bytes,
   output logic              out_valid,
   output logic              slot_free_c
);

   // A word leaving this cycle frees the slot for a same-cycle reload.
   assign slot_free_c = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_bytes <= '0;
         out_valid <= 1'b0;
      end else if (load) begin
         out_data  <= load_word.data;
         out_bytes <= load_word.bytes;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_word_packer.sv
// Drains the byte FIFO and packs bytes little-endian into words, with flush
// support for emitting a trailing partial word.
module fifo_word_packer
   import fifo_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] fifo_out,
   input  logic              fifo_empty,
   output logic              pop,
   input  logic              flush,
   output logic [WORD_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_bytes,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              flush_done
);

   logic              pend;
   logic [CNT_W-1:0]  fill;
   logic [CNT_W-1:0]  fill_n;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] acc_n;
   logic              flush_req;
   logic              flush_req_n;
   logic              flush_done_n;
   logic              slot_free;
   logic              load;
   word_t             load_word;
   logic [WORD_W-1:0] partial_word;

   // Counting the in-flight byte keeps the accumulator from being over-read.
   assign pop = !rst && !fifo_empty && !flush_req &&
                ((fill + CNT_W'(pend)) < CNT_W'(BYTES_PER_WORD));

   // Accumulated bytes with everything at or above fill forced to zero.
   always_comb begin
      partial_word = '0;
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
         if (CNT_W'(i) < fill) begin
            partial_word[i*BYTE_W +: BYTE_W] = acc[i*BYTE_W +: BYTE_W];
         end
      end
   end

   always_comb begin
      acc_n        = acc;
      fill_n       = fill;
      flush_req_n  = flush_req;
      flush_done_n = 1'b0;
      load         = 1'b0;
      load_word    = '0;

      if (pend && (fill == CNT_W'(BYTES_PER_WORD - 1))) begin
         if (slot_free) begin
            load            = 1'b1;
            load_word.data  = {fifo_out, acc[WORD_W-BYTE_W-1:0]};
            load_word.bytes = CNT_W'(BYTES_PER_WORD);
            fill_n          = '0;
         end else begin
            acc_n[WORD_W-1 -: BYTE_W] = fifo_out;
            fill_n                    = CNT_W'(BYTES_PER_WORD);
         end
      end else if (pend) begin
         for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            if (CNT_W'(i) == fill) begin
               acc_n[i*BYTE_W +: BYTE_W] = fifo_out;
            end
         end
         fill_n = fill + CNT_W'(1);
      end else if (fill == CNT_W'(BYTES_PER_WORD)) begin
         // Full word parked in acc while the slot was busy.
         if (slot_free) begin
            load            = 1'b1;
            load_word.data  = acc;
            load_word.bytes = CNT_W'(BYTES_PER_WORD);
            fill_n          = '0;
         end
      end else if (flush_req && slot_free) begin
         if (fill != '0) begin
            load            = 1'b1;
            load_word.data  = partial_word;
            load_word.bytes = fill;
            fill_n          = '0;
         end else begin
            flush_done_n = 1'b1;
            flush_req_n  = 1'b0;
         end
      end

      if (flush && !flush_req) begin
         flush_req_n = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend       <= 1'b0;
         fill       <= '0;
         acc        <= '0;
         flush_req  <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         pend       <= pop;
         fill       <= fill_n;
         acc        <= acc_n;
         flush_req  <= flush_req_n;
         flush_done <= flush_done_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_fill_range: assert (fill <= CNT_W'(BYTES_PER_WORD));
      end
   end

   word_out_slot u_slot (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .load_word   (load_word),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_bytes   (out_bytes),
      .out_valid   (out_valid),
      .slot_free_c (slot_free)
   );

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural 8-entry FIFO, directed vectors and a
// randomized byte-stream comparison against the pushed sequence.
module tb_fifo_word_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  fifo_out = 8'h00;
   logic        fifo_empty = 1'b1;
   logic        pop;
   logic        flush = 1'b0;
   logic [31:0] out_data;
   logic [2:0]  out_bytes;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        flush_done;

   fifo_word_packer dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_out   (fifo_out),
      .fifo_empty (fifo_empty),
      .pop        (pop),
      .flush      (flush),
      .out_data   (out_data),
      .out_bytes  (out_bytes),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .flush_done (flush_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [2:0]  n;
   } word_rec_t;

   typedef struct {
      logic [31:0] din;
      int          n;
      bit          fl;
      logic [31:0] ed;
      logic [2:0]  eb;
   } vec_t;

   logic [7:0] fq[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   word_rec_t  words_q[$];
   logic       push_en = 1'b0;
   logic [7:0] push_data = 8'h00;
   int cyc = 0, last_pop = 0, pop_cnt = 0, pop_err = 0, fd_cnt = 0;
   int hold_err = 0, pad_err = 0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_d = '0;
   logic [2:0]  prev_n = '0;
   int total = 0, bad = 0;

   function automatic bit pad_ok(input logic [31:0] d, input logic [2:0] n);
      for (int i = 0; i < 4; i++) begin
         if (i >= int'(n) && d[8*i +: 8] != 8'h00) return 1'b0;
      end
      return 1'b1;
   endfunction

   // FIFO model with registered read data, plus output/hold/pad monitors.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pop) begin
         pop_cnt  <= pop_cnt + 1;
         last_pop <= cyc + 1;
         if (fq.size() == 0) pop_err <= pop_err + 1;
         else fifo_out <= fq.pop_front();
      end
      if (push_en) fq.push_back(push_data);
      fifo_empty <= (fq.size() == 0);
      if (flush_done) fd_cnt <= fd_cnt + 1;
      if (out_valid && out_ready) begin
         words_q.push_back('{d: out_data, n: out_bytes});
         for (int i = 0; i < 4; i++) begin
            if (i < int'(out_bytes)) got_q.push_back(out_data[8*i +: 8]);
         end
         if (!pad_ok(out_data, out_bytes)) pad_err <= pad_err + 1;
      end
      if (!rst && prev_hold && (!out_valid || out_data != prev_d || out_bytes != prev_n))
         hold_err <= hold_err + 1;
      prev_hold <= out_valid && !out_ready && !rst;
      prev_d    <= out_data;
      prev_n    <= out_bytes;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      push_en   = 1'b1;
      push_data = b;
      tick();
      push_en   = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic wait_words(input string nm, input int n, input int budget);
      int k = 0;
      while (words_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      check(nm, 32'(words_q.size() >= n), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[5];
      int p0, fd0, w0, k, mism;

      tbl[0] = '{din: 32'h44332211, n: 4, fl: 1'b0, ed: 32'h44332211, eb: 3'd4};
      tbl[1] = '{din: 32'h00CCBBAA, n: 3, fl: 1'b1, ed: 32'h00CCBBAA, eb: 3'd3};
      tbl[2] = '{din: 32'h000000DE, n: 1, fl: 1'b1, ed: 32'h000000DE, eb: 3'd1};
      tbl[3] = '{din: 32'h00000201, n: 2, fl: 1'b1, ed: 32'h00000201, eb: 3'd2};
      tbl[4] = '{din: 32'hF3F2F1F0, n: 4, fl: 1'b0, ed: 32'hF3F2F1F0, eb: 3'd4};

      // Reset state
      rst = 1'b1;
      tick(); tick(); tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_bytes", 32'(out_bytes), 32'd0);
      check("rst_flush_done", 32'(flush_done), 32'd0);
      check("rst_pop", 32'(pop), 32'd0);
      rst = 1'b0;
      tick();

      // Directed vectors: full words and flushed partial words
      for (int v = 0; v < 5; v++) begin
         words_q.delete();
         p0  = pop_cnt;
         fd0 = fd_cnt;
         for (int i = 0; i < tbl[v].n; i++) push(tbl[v].din[8*i +: 8]);
         if (tbl[v].fl) begin
            tick(); tick(); tick();
            pulse_flush();
         end else begin
            k = 0;
            while (!out_valid && k < 10) begin
               tick();
               k++;
            end
            check($sformatf("vec%0d_latency", v), 32'(cyc - last_pop), 32'd1);
         end
         wait_words($sformatf("vec%0d_word_seen", v), 1, 20);
         check($sformatf("vec%0d_data", v), words_q[0].d, tbl[v].ed);
         check($sformatf("vec%0d_bytes", v), 32'(words_q[0].n), 32'(tbl[v].eb));
         check($sformatf("vec%0d_pops", v), 32'(pop_cnt - p0), 32'(tbl[v].n));
         tick(); tick(); tick(); tick(); tick();
         check($sformatf("vec%0d_flush_done_cnt", v), 32'(fd_cnt - fd0),
               tbl[v].fl ? 32'd1 : 32'd0);
      end

      // Backpressure: second word parks in acc, pop stalls, nothing lost
      words_q.delete();
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push(8'(i));
      for (int i = 0; i < 10; i++) tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, 32'h04030201);
      check("bp_out_bytes", 32'(out_bytes), 32'd4);
      check("bp_fill_full", 32'(dut.fill), 32'd4);
      push(8'h09);
      tick(); tick();
      check("bp_fifo_nonempty", 32'(fifo_empty), 32'd0);
      check("bp_pop_stalled", 32'(pop), 32'd0);
      out_ready = 1'b1;
      wait_words("bp_two_words", 2, 20);
      check("bp_word0", words_q[0].d, 32'h04030201);
      check("bp_word1", words_q[1].d, 32'h08070605);
      tick(); tick(); tick();
      pulse_flush();
      wait_words("bp_tail_word", 3, 20);
      check("bp_tail_data", words_q[2].d, 32'h00000009);
      check("bp_tail_bytes", 32'(words_q[2].n), 32'd1);
      tick(); tick(); tick();

      // Flush with nothing buffered: flush_done only, exactly one cycle
      w0 = words_q.size();
      pulse_flush();
      check("eflush_done_early", 32'(flush_done), 32'd0);
      tick();
      check("eflush_done", 32'(flush_done), 32'd1);
      tick();
      check("eflush_done_pulse", 32'(flush_done), 32'd0);
      check("eflush_no_word", 32'(words_q.size()), 32'(w0));

      // Reset with a byte in flight mid-word: that byte is dropped
      words_q.delete();
      push(8'h55);
      push(8'h66);
      rst = 1'b1;
      push(8'h77);
      check("mrst_pop_forced_low", 32'(pop), 32'd0);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_fill", 32'(dut.fill), 32'd0);
      rst = 1'b0;
      push(8'h88);
      push(8'h99);
      wait_words("mrst_word_seen", 1, 20);
      check("mrst_word", words_q[0].d, 32'h99887766);
      check("mrst_bytes", 32'(words_q[0].n), 32'd4);

      // Random traffic: output byte stream must equal the push stream
      for (int i = 0; i < 20; i++) tick();
      got_q.delete();
      exp_q.delete();
      for (int c = 0; c < 10000; c++) begin
         out_ready = ($urandom_range(0, 3) != 0) || (c > 5000 && c < 6000);
         flush     = ($urandom_range(0, 299) == 0);
         push_en   = (fq.size() < 8) && ($urandom_range(0, 2) != 0);
         push_data = 8'($urandom);
         if (push_en) exp_q.push_back(push_data);
         tick();
      end
      push_en   = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      pulse_flush();
      for (int i = 0; i < 30; i++) tick();
      pulse_flush();
      for (int i = 0; i < 20; i++) tick();
      check("rand_byte_count", 32'(got_q.size()), 32'(exp_q.size()));
      mism = 0;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         if (got_q[i] !== exp_q[i]) mism++;
      end
      check("rand_byte_mismatches", 32'(mism), 32'd0);
      check("rand_fifo_drained", 32'(fq.size()), 32'd0);
      check("pop_while_empty", 32'(pop_err), 32'd0);
      check("hold_stability", 32'(hold_err), 32'd0);
      check("partial_zero_pad", 32'(pad_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
